// File: rtl/led_rate_ctrl.sv
// Pushbutton front end for the LED blink counter: synchronise, debounce, and
// turn short/long presses into divider updates with a one-cycle write strobe.
module led_rate_ctrl #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned LONG_CYCLES = 100_000_000,
  parameter int unsigned DIV_MAX     = 20,
  parameter int unsigned DIV_DEFAULT = 1
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       btn_i,
  output logic [4:0] div_o,
  output logic       wren_o
);

  localparam int unsigned DB_W   = (DB_CYCLES   > 1) ? $clog2(DB_CYCLES)   : 1;
  localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [4:0]        DIV_TOP   = 5'(DIV_MAX);
  localparam logic [4:0]        DIV_DEF   = 5'(DIV_DEFAULT);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic              sync1, btn_s, btn_db;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [4:0]        div_q, div_n;
  logic              wren_q, wren_n;
  state_t            state, state_n;

  always_ff @(posedge clk100) begin
    if (rst) begin
      sync1  <= 1'b0;
      btn_s  <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_i;
      btn_s <= sync1;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      div_q    <= DIV_DEF;
      wren_q   <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      div_q    <= div_n;
      wren_q   <= wren_n;
    end
  end

  // IDLE is only ever entered with btn_db low, so btn_db high there is a rising edge.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    div_n   = div_q;
    wren_n  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_db) begin
          state_n = HELD;
          hold_n  = '0;
        end
      end
      HELD: begin
        if (!btn_db) begin
          div_n   = (div_q == DIV_TOP) ? 5'd1 : div_q + 5'd1;
          wren_n  = 1'b1;
          state_n = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          div_n   = DIV_DEF;
          wren_n  = 1'b1;
          state_n = LONG;
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      LONG: begin
        if (!btn_db) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;

endmodule
